frame_sequencer: RTL and testbench
==================================

# frame_sequencer

APU frame sequencer: divides the 1.79 MHz system clock into quarter-frame and half-frame strobes that clock the envelope, length-counter and sweep logic of every sound channel (noise, pulse, triangle). It owns the $4017 frame-counter register semantics (4-step/5-step mode, IRQ inhibit) and raises the frame interrupt. It sits between the register-write decoder and the channel blocks: its `enable_240hz` drives each channel's `enable_240hz` input, and `enable_120hz` drives half-frame logic.

## Interface
- `QUARTER`, default 7457: clk cycles per sequencer step; legal range 2..8191.
- `clk`  input  1  system clock (1.79 MHz APU/CPU rate); one clock domain.
- `rst_n`  input  1  asynchronous active-low reset.
- `reg_4017`  input  8  frame-counter register value; bit7 = mode (0 = 4-step, 1 = 5-step), bit6 = IRQ inhibit; other bits ignored.
- `reg_4017_event`  input  1  one-cycle write strobe; `reg_4017` is valid in the same cycle.
- `irq_ack`  input  1  one-cycle status-read strobe; clears the frame IRQ.
- `enable_240hz`  output  1  quarter-frame strobe, one clk wide.
- `enable_120hz`  output  1  half-frame strobe, one clk wide.
- `frame_irq`  output  1  level frame interrupt, held until cleared.
- `frame_step`  output  3  current step index, 0..4 (debug/verification).

## Operation
- State: `cycle_cnt` (13 bit, 0..QUARTER-1), `step` (3 bit), `mode`, `inhibit`, plus registered outputs.
- `cycle_cnt` increments every clk. At terminal count (`cycle_cnt == QUARTER-1`) it returns to 0 and `step` is evaluated:
  - 4-step mode: steps 0,1,2,3 each emit a quarter strobe; steps 1 and 3 also emit a half strobe; step 3 wraps to 0 and, if `inhibit == 0`, sets `frame_irq`.
  - 5-step mode: steps 0,1,2,4 emit a quarter strobe; steps 1 and 4 emit a half strobe; step 3 emits nothing; step 4 wraps to 0. No IRQ is raised in 5-step mode.
  - Otherwise `step` increments.
- A `reg_4017_event` writes `mode <= reg_4017[7]` and `inhibit <= reg_4017[6]`, and forces `cycle_cnt <= 0` and `step <= 0`.
  - If `reg_4017[7] == 1`, the write emits a quarter and half strobe immediately (one pulse each).
  - If `reg_4017[6] == 1`, the write clears `frame_irq`.
- `irq_ack` clears `frame_irq`.
- Priority within one cycle:
  - A write overrides terminal-count processing: the terminal strobe and IRQ set are suppressed, and only write-generated strobes appear.
  - An IRQ set overrides `irq_ack`.
  - An inhibit-write clear overrides everything.
- A `step` value outside the legal range for the current mode (e.g. a stale 4 after switching to 4-step) is treated as terminal: wrap to 0, no strobes.

## Timing
- Reset values: `enable_240hz = 0`, `enable_120hz = 0`, `frame_irq = 0`, `frame_step = 0`, `cycle_cnt = 0`, `mode = 0` (4-step), `inhibit = 0`.
- All outputs are registered.
- Strobes assert in the cycle after the terminal count (or after the write) and last exactly one clk.
- After reset release, or after a write in cycle W, the first terminal count is the QUARTER-th clk. The first step strobe is therefore seen QUARTER cycles after W+1.
- A 4-step frame is 4·QUARTER clks. A 5-step frame is 5·QUARTER clks.
- `frame_irq` rises in the same cycle as the step-3 strobes and falls in the cycle after `irq_ack` or the inhibit write.
- `frame_step` reflects the registered `step` and updates in the cycle after terminal count.
- Asserting reset mid-frame returns every register to its reset value immediately (asynchronous); sequencing restarts at step 0 on the first clk edge after deassertion.

## Test plan
- Reset, QUARTER=8, no writes:
  - Quarter strobes at clk 8, 16, 24, 32, 40…
  - Half strobes at 16, 32…
  - `frame_irq` rises at clk 32 and stays high.
- Write `reg_4017 = 0x80` (5-step) at clk W:
  - Quarter and half strobes at W+1.
  - Quarter strobes at W+9, W+17, W+25, W+41.
  - Half strobes at W+17, W+41.
  - No strobe at W+33.
  - `frame_irq` stays 0 across 3 frames.
- 4-step mode with pending IRQ:
  - Pulse `irq_ack` → `frame_irq` low the next cycle, re-raised at the next frame end.
  - Write `0x40` → IRQ cleared and never re-raised.
- Write coincident with terminal count of step 3 (value 0x00):
  - No strobe and no IRQ that cycle.
  - Next quarter strobe arrives exactly QUARTER cycles later, with `frame_step = 1`.
- `irq_ack` in the same cycle as the IRQ set → `frame_irq` = 1.
- Assert `rst_n` low mid-step 2 for 3 cycles:
  - All outputs 0 immediately.
  - After release, the first quarter strobe arrives at QUARTER clks and the mode is 4-step.

Source files
------------

// File: rtl/frame_sequencer.sv
// frame_sequencer
//   APU frame sequencer. Divides the system clock into quarter-frame
//   (enable_240hz) and half-frame (enable_120hz) strobes, implements the
//   $4017 frame-counter semantics (4-step / 5-step mode, IRQ inhibit) and
//   raises the level frame interrupt.
//
// Ports
//   clk            system clock, single domain
//   rst_n          asynchronous active-low reset
//   reg_4017       frame-counter register value (bit7 mode, bit6 inhibit)
//   reg_4017_event one-cycle write strobe qualifying reg_4017
//   irq_ack        one-cycle status-read strobe, clears frame_irq
//   enable_240hz   quarter-frame strobe, one clk wide (registered)
//   enable_120hz   half-frame strobe, one clk wide (registered)
//   frame_irq      level frame interrupt (registered)
//   frame_step     current sequencer step 0..4 (registered)
module frame_sequencer #(
  parameter int QUARTER = 7457
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] reg_4017,
  input  logic       reg_4017_event,
  input  logic       irq_ack,
  output logic       enable_240hz,
  output logic       enable_120hz,
  output logic       frame_irq,
  output logic [2:0] frame_step
);

  localparam logic [12:0] TERM = 13'(QUARTER - 1);

  logic [12:0] cnt_q, cnt_d;
  logic [2:0]  step_q, step_d;
  logic        mode_q, mode_d;
  logic        inh_q, inh_d;
  logic        qtr_q, qtr_d;
  logic        half_q, half_d;
  logic        irq_q, irq_d;
  logic        irq_set;

  // Only the mode and inhibit bits of $4017 matter here.
  logic        unused_reg_bits;
  assign unused_reg_bits = ^reg_4017[5:0];

  always_comb begin
    cnt_d   = cnt_q + 13'd1;
    step_d  = step_q;
    mode_d  = mode_q;
    inh_d   = inh_q;
    qtr_d   = 1'b0;
    half_d  = 1'b0;
    irq_d   = irq_q;
    irq_set = 1'b0;

    if (cnt_q == TERM) begin
      cnt_d = '0;
      if (!mode_q) begin
        // 4-step sequence; a stale step outside 0..3 just wraps silently.
        case (step_q)
          3'd0: begin qtr_d = 1'b1; step_d = 3'd1; end
          3'd1: begin qtr_d = 1'b1; half_d = 1'b1; step_d = 3'd2; end
          3'd2: begin qtr_d = 1'b1; step_d = 3'd3; end
          3'd3: begin
            qtr_d   = 1'b1;
            half_d  = 1'b1;
            step_d  = 3'd0;
            irq_set = !inh_q;
          end
          default: step_d = 3'd0;
        endcase
      end else begin
        // 5-step sequence: step 3 is a silent gap, never raises an IRQ.
        case (step_q)
          3'd0: begin qtr_d = 1'b1; step_d = 3'd1; end
          3'd1: begin qtr_d = 1'b1; half_d = 1'b1; step_d = 3'd2; end
          3'd2: begin qtr_d = 1'b1; step_d = 3'd3; end
          3'd3: step_d = 3'd4;
          3'd4: begin qtr_d = 1'b1; half_d = 1'b1; step_d = 3'd0; end
          default: step_d = 3'd0;
        endcase
      end
    end

    // IRQ priority, lowest first: ack clear, terminal set, inhibit-write clear.
    if (irq_ack) irq_d = 1'b0;

    if (reg_4017_event) begin
      // A write discards whatever the terminal count produced this cycle.
      mode_d = reg_4017[7];
      inh_d  = reg_4017[6];
      cnt_d  = '0;
      step_d = 3'd0;
      qtr_d  = reg_4017[7];
      half_d = reg_4017[7];
      if (reg_4017[6]) irq_d = 1'b0;
    end else if (irq_set) begin
      irq_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      step_q <= '0;
      mode_q <= 1'b0;
      inh_q  <= 1'b0;
      qtr_q  <= 1'b0;
      half_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      step_q <= step_d;
      mode_q <= mode_d;
      inh_q  <= inh_d;
      qtr_q  <= qtr_d;
      half_q <= half_d;
      irq_q  <= irq_d;
    end
  end

  assign enable_240hz = qtr_q;
  assign enable_120hz = half_q;
  assign frame_irq    = irq_q;
  assign frame_step   = step_q;

endmodule

// File: tb/tb_frame_sequencer.sv
module tb_frame_sequencer;

  localparam int Q = 8;

  logic       clk;
  logic       rst_n;
  logic [7:0] reg_4017;
  logic       reg_4017_event;
  logic       irq_ack;
  logic       enable_240hz;
  logic       enable_120hz;
  logic       frame_irq;
  logic [2:0] frame_step;

  int ncmp;
  int nfail;

  frame_sequencer #(.QUARTER(Q)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .reg_4017       (reg_4017),
    .reg_4017_event (reg_4017_event),
    .irq_ack        (irq_ack),
    .enable_240hz   (enable_240hz),
    .enable_120hz   (enable_120hz),
    .frame_irq      (frame_irq),
    .frame_step     (frame_step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int k, input logic [7:0] obs,
                     input logic [7:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s at k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  // Advance one clock edge and settle away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Free-running 4-step expectations, k = edges since reset release / write.
  task automatic chk_4step(input int k);
    chk("q4", k, {7'd0, enable_240hz}, {7'd0, (k % 8 == 0)});
    chk("h4", k, {7'd0, enable_120hz}, {7'd0, (k % 16 == 0)});
    chk("irq4", k, {7'd0, frame_irq}, {7'd0, (k >= 32)});
    chk("step4", k, {5'd0, frame_step}, 8'((k / 8) % 4));
  endtask

  initial begin
    int r;
    ncmp = 0;
    nfail = 0;
    rst_n = 1'b0;
    reg_4017 = 8'h00;
    reg_4017_event = 1'b0;
    irq_ack = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_q", 0, {7'd0, enable_240hz}, 8'd0);
    chk("rst_h", 0, {7'd0, enable_120hz}, 8'd0);
    chk("rst_irq", 0, {7'd0, frame_irq}, 8'd0);
    chk("rst_step", 0, {5'd0, frame_step}, 8'd0);
    rst_n = 1'b1;

    // Phase A: free-running 4-step, IRQ rises at 32 and holds
    for (int k = 1; k <= 40; k++) begin
      tick();
      chk_4step(k);
    end

    // Phase B: irq_ack clears next cycle; re-raised at frame end (64)
    tick();                      // edge 41
    irq_ack = 1'b1;
    tick();                      // edge 42
    irq_ack = 1'b0;
    chk("ack_clr", 42, {7'd0, frame_irq}, 8'd0);
    for (int k = 43; k <= 64; k++) begin
      tick();
      chk("irq_re", k, {7'd0, frame_irq}, {7'd0, (k == 64)});
    end
    chk("q64", 64, {7'd0, enable_240hz}, 8'd1);
    chk("h64", 64, {7'd0, enable_120hz}, 8'd1);

    // Phase C: ack coincident with IRQ set at 96 -> set wins
    tick();                      // 65
    irq_ack = 1'b1;
    tick();                      // 66
    irq_ack = 1'b0;
    chk("ack2_clr", 66, {7'd0, frame_irq}, 8'd0);
    for (int k = 67; k <= 95; k++) tick();
    chk("irq95", 95, {7'd0, frame_irq}, 8'd0);
    irq_ack = 1'b1;
    tick();                      // 96: terminal step 3 with ack
    irq_ack = 1'b0;
    chk("ack_vs_set", 96, {7'd0, frame_irq}, 8'd1);
    chk("q96", 96, {7'd0, enable_240hz}, 8'd1);
    tick();                      // 97
    chk("irq97", 97, {7'd0, frame_irq}, 8'd1);

    // Phase D: write 0x40 at edge 98 clears IRQ, never re-raised
    reg_4017 = 8'h40;
    reg_4017_event = 1'b1;
    tick();                      // 98
    reg_4017_event = 1'b0;
    chk("inh_clr", 98, {7'd0, frame_irq}, 8'd0);
    chk("inh_noq", 98, {7'd0, enable_240hz}, 8'd0);
    for (int k = 99; k <= 161; k++) begin
      tick();
      chk("inh_irq", k, {7'd0, frame_irq}, 8'd0);
      chk("inh_q", k, {7'd0, enable_240hz}, {7'd0, ((k - 98) % 8 == 0)});
    end

    // Phase E: write 0x00 coincident with step-3 terminal at edge 162
    reg_4017 = 8'h00;
    reg_4017_event = 1'b1;
    tick();                      // 162
    reg_4017_event = 1'b0;
    chk("wt_q", 162, {7'd0, enable_240hz}, 8'd0);
    chk("wt_h", 162, {7'd0, enable_120hz}, 8'd0);
    chk("wt_irq", 162, {7'd0, frame_irq}, 8'd0);
    chk("wt_step", 162, {5'd0, frame_step}, 8'd0);
    for (int k = 163; k <= 169; k++) begin
      tick();
      chk("wt_gap", k, {7'd0, enable_240hz}, 8'd0);
    end
    tick();                      // 170
    chk("wt_next_q", 170, {7'd0, enable_240hz}, 8'd1);
    chk("wt_next_step", 170, {5'd0, frame_step}, 8'd1);

    // Phase F: write 0x80 (5-step) sampled at edge 171, three frames
    reg_4017 = 8'h80;
    reg_4017_event = 1'b1;
    tick();                      // 171
    reg_4017_event = 1'b0;
    chk("w5_q", 171, {7'd0, enable_240hz}, 8'd1);
    chk("w5_h", 171, {7'd0, enable_120hz}, 8'd1);
    for (int k = 172; k <= 291; k++) begin
      tick();
      r = (k - 171) % 40;
      chk("q5", k, {7'd0, enable_240hz},
          {7'd0, (r == 8 || r == 16 || r == 24 || r == 0)});
      chk("h5", k, {7'd0, enable_120hz}, {7'd0, (r == 16 || r == 0)});
      chk("irq5", k, {7'd0, frame_irq}, 8'd0);
      chk("step5", k, {5'd0, frame_step}, 8'(r / 8));
    end

    // Phase G: async reset in the middle of step 2 (edge 310)
    for (int k = 292; k <= 310; k++) tick();
    chk("pre_rst_step", 310, {5'd0, frame_step}, 8'd2);
    rst_n = 1'b0;
    #1;
    chk("arst_q", 310, {7'd0, enable_240hz}, 8'd0);
    chk("arst_h", 310, {7'd0, enable_120hz}, 8'd0);
    chk("arst_irq", 310, {7'd0, frame_irq}, 8'd0);
    chk("arst_step", 310, {5'd0, frame_step}, 8'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      chk_4step(k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
